// File: rtl/cache_load_seq.sv
// Cache array initialisation sequencer: walks every set/way pair once.
// Each pair gets either a constant clear vector or one beat from a ready/valid stream.
module cache_load_seq #(
    parameter int unsigned SETS      = 64,
    parameter int unsigned WAYS      = 4,
    parameter int unsigned DATA_W    = 8,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
    localparam int unsigned SET_BITS = $clog2(SETS),
    localparam int unsigned WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                mode_i,
    input  logic                abort_i,
    input  logic                s_valid_i,
    input  logic [DATA_W-1:0]   s_data_i,
    output logic                s_ready_o,
    output logic                we_o,
    output logic [SET_BITS-1:0] addr_o,
    output logic [WAY_BITS-1:0] way_o,
    output logic [DATA_W-1:0]   vect_o,
    output logic                ready_o,
    output logic                busy_o,
    output logic                done_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SET_BITS-1:0] set_q, set_d;
    logic [WAY_BITS-1:0] way_q, way_d;
    logic                wr;
    logic                last_way;
    logic                last_set;

    assign last_way = (way_q == WAY_BITS'(WAYS - 1));
    assign last_set = (set_q == SET_BITS'(SETS - 1));

    // State and position counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            set_q   <= '0;
            way_q   <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            way_q   <= way_d;
        end
    end

    // Next state, counter advance and write-port drive
    always_comb begin
        state_d   = state_q;
        set_d     = set_q;
        way_d     = way_q;
        wr        = 1'b0;
        s_ready_o = 1'b0;
        we_o      = 1'b0;
        addr_o    = '0;
        way_o     = '0;
        vect_o    = '0;
        ready_o   = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_o = 1'b1;
                set_d   = '0;
                way_d   = '0;
                if (start_i) begin
                    state_d = mode_i ? ST_LOAD : ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                busy_o = 1'b1;
                if (abort_i) begin
                    state_d = ST_IDLE;
                    set_d   = '0;
                    way_d   = '0;
                end else begin
                    wr     = 1'b1;
                    vect_o = CLEAR_VAL;
                end
            end
            ST_LOAD: begin
                busy_o = 1'b1;
                if (abort_i) begin
                    state_d = ST_IDLE;
                    set_d   = '0;
                    way_d   = '0;
                end else begin
                    s_ready_o = 1'b1;
                    wr        = s_valid_i;
                    if (s_valid_i) begin
                        vect_o = s_data_i;
                    end
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Way is the inner loop; the final pair wraps both counters back to zero
        if (wr) begin
            we_o   = 1'b1;
            addr_o = set_q;
            way_o  = way_q;
            if (last_way) begin
                way_d = '0;
                if (last_set) begin
                    set_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    set_d = set_q + SET_BITS'(1);
                end
            end else begin
                way_d = way_q + WAY_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_cache_load_seq.sv
// Randomized and directed bench for cache_load_seq against a linear-index reference model.
module tb_cache_load_seq;

    localparam int unsigned SETS     = 4;
    localparam int unsigned WAYS     = 2;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned TOTAL    = SETS * WAYS;
    localparam int unsigned SET_BITS = 2;
    localparam int unsigned WAY_BITS = 1;
    localparam logic [DATA_W-1:0] CLEAR_VAL = 8'h00;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                start_i;
    logic                mode_i;
    logic                abort_i;
    logic                s_valid_i;
    logic [DATA_W-1:0]   s_data_i;
    logic                s_ready_o;
    logic                we_o;
    logic [SET_BITS-1:0] addr_o;
    logic [WAY_BITS-1:0] way_o;
    logic [DATA_W-1:0]   vect_o;
    logic                ready_o;
    logic                busy_o;
    logic                done_o;

    cache_load_seq #(
        .SETS      (SETS),
        .WAYS      (WAYS),
        .DATA_W    (DATA_W),
        .CLEAR_VAL (CLEAR_VAL)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .mode_i    (mode_i),
        .abort_i   (abort_i),
        .s_valid_i (s_valid_i),
        .s_data_i  (s_data_i),
        .s_ready_o (s_ready_o),
        .we_o      (we_o),
        .addr_o    (addr_o),
        .way_o     (way_o),
        .vect_o    (vect_o),
        .ready_o   (ready_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: phase 0 idle, 1 clear, 2 load, 3 done; k = writes done so far
    int phase;
    int k;
    int n_checks;
    int n_fail;
    int obs_we;
    int obs_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock: drive at negedge, compare settled outputs, advance model at posedge
    task automatic cycle(input logic r, input logic st, input logic md, input logic ab,
                         input logic v, input logic [DATA_W-1:0] d);
        logic e_we;
        logic e_sr;
        int   e_set;
        int   e_way;
        int   e_vect;
        @(negedge clk_i);
        rst_i     = r;
        start_i   = st;
        mode_i    = md;
        abort_i   = ab;
        s_valid_i = v;
        s_data_i  = d;
        #1;
        e_sr   = (phase == 2) && !ab;
        e_we   = ((phase == 1) && !ab) || ((phase == 2) && !ab && v);
        e_set  = e_we ? (k / WAYS) : 0;
        e_way  = e_we ? (k % WAYS) : 0;
        e_vect = e_we ? ((phase == 1) ? int'(CLEAR_VAL) : int'(d)) : 0;
        check("ready_o",   32'(ready_o),   32'(phase == 0));
        check("busy_o",    32'(busy_o),    32'(phase == 1 || phase == 2));
        check("done_o",    32'(done_o),    32'(phase == 3));
        check("s_ready_o", 32'(s_ready_o), 32'(e_sr));
        check("we_o",      32'(we_o),      32'(e_we));
        check("addr_o",    32'(addr_o),    32'(e_set));
        check("way_o",     32'(way_o),     32'(e_way));
        check("vect_o",    32'(vect_o),    32'(e_vect));
        if (we_o === 1'b1) obs_we++;
        if (done_o === 1'b1) obs_done++;
        @(posedge clk_i);
        if (r) begin
            phase = 0;
            k     = 0;
        end else begin
            case (phase)
                0: if (st) begin
                    phase = md ? 2 : 1;
                    k     = 0;
                end
                1, 2: if (ab) begin
                    phase = 0;
                    k     = 0;
                end else if (e_we) begin
                    k++;
                    if (k == TOTAL) begin
                        phase = 3;
                        k     = 0;
                    end
                end
                default: phase = 0;
            endcase
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom));
    endtask

    initial begin
        int beats;
        n_checks  = 0;
        n_fail    = 0;
        obs_we    = 0;
        obs_done  = 0;
        phase     = 0;
        k         = 0;
        rst_i     = 1'b1;
        start_i   = 1'b0;
        mode_i    = 1'b0;
        abort_i   = 1'b0;
        s_valid_i = 1'b0;
        s_data_i  = '0;

        // Reset held for a few edges, idle outputs checked by the model
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        idle_cycles(2);

        // Clear sequence
        obs_we = 0; obs_done = 0;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        idle_cycles(12);
        check("clear_writes", 32'(obs_we), 32'd8);
        check("clear_done",   32'(obs_done), 32'd1);
        check("clear_ready",  32'(ready_o), 32'd1);

        // Stream load with valid low every other cycle
        obs_we = 0; obs_done = 0; beats = 0;
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 1 && beats < 8) begin
                cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'(8'h10 + beats));
                beats++;
            end else begin
                cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hEE);
            end
        end
        check("load_writes", 32'(obs_we), 32'd8);
        check("load_done",   32'(obs_done), 32'd1);

        // Abort on the fourth clear cycle, then a fresh clear from 0/0
        obs_we = 0; obs_done = 0;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A);
        idle_cycles(3);
        check("abort_writes", 32'(obs_we), 32'd3);
        check("abort_done",   32'(obs_done), 32'd0);
        check("abort_ready",  32'(ready_o), 32'd1);
        obs_we = 0; obs_done = 0;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        idle_cycles(11);
        check("reclear_writes", 32'(obs_we), 32'd8);
        check("reclear_done",   32'(obs_done), 32'd1);

        // Reset after five load beats, then a full load from 0/0
        obs_we = 0; obs_done = 0;
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'(8'h20 + i));
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h25);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h26);
        check("rst_writes", 32'(obs_we), 32'd6);
        check("rst_done",   32'(obs_done), 32'd0);
        obs_we = 0; obs_done = 0;
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'(8'h30 + i));
        idle_cycles(2);
        check("reload_writes", 32'(obs_we), 32'd8);
        check("reload_done",   32'(obs_done), 32'd1);

        // start_i while busy is ignored; abort beats the final write
        obs_we = 0; obs_done = 0;
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'($urandom), 1'b0, 1'b1, 8'(8'h40 + i));
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h47);
        idle_cycles(3);
        check("abort_last_writes", 32'(obs_we), 32'd7);
        check("abort_last_done",   32'(obs_done), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cycle(1'($urandom_range(0, 199) == 0),
                  1'($urandom_range(0, 3) == 0),
                  1'($urandom),
                  1'($urandom_range(0, 39) == 0),
                  1'($urandom),
                  8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_load_seq.md
CACHE_LOAD_SEQ -- requirements
Module: cache_load_seq

Interface
REQ-001 SHALL have parameter SETS, default 64, number of cache sets to initialise (>=2, need not be a power of two).
REQ-002 SHALL have parameter WAYS, default 4, ways per set (>=1).
REQ-003 SHALL have parameter DATA_W, default 8, width of the per-way write vector.
REQ-004 SHALL have parameter CLEAR_VAL, default '0, DATA_W-bit vector written in clear mode.
REQ-005 SHALL derive SET_BITS = $clog2(SETS) and WAY_BITS = max(1, $clog2(WAYS)).
REQ-006 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start_i, input, 1, begin a sequence; sampled only in IDLE.
REQ-009 SHALL have port mode_i, input, 1, sequence mode sampled with start_i: 0 = clear, 1 = stream load.
REQ-010 SHALL have port abort_i, input, 1, terminate the running sequence.
REQ-011 SHALL have port s_valid_i, input, 1, stream beat valid.
REQ-012 SHALL have port s_data_i, input, DATA_W, stream beat data.
REQ-013 SHALL have port s_ready_o, output, 1, stream beat accept.
REQ-014 SHALL have port we_o, output, 1, array write strobe.
REQ-015 SHALL have port addr_o, output, SET_BITS, set index of the write.
REQ-016 SHALL have port way_o, output, WAY_BITS, way index of the write.
REQ-017 SHALL have port vect_o, output, DATA_W, write data.
REQ-018 SHALL have port ready_o, output, 1, high only in IDLE.
REQ-019 SHALL have port busy_o, output, 1, high in CLEAR or LOAD.
REQ-020 SHALL have port done_o, output, 1, one-cycle pulse on normal completion.

Function
REQ-021 SHALL implement states IDLE, CLEAR, LOAD, DONE.
REQ-022 SHALL transition IDLE->CLEAR when start_i=1, mode_i=0; IDLE->LOAD when start_i=1, mode_i=1; mode held internally for the whole sequence.
REQ-023 SHALL ignore start_i and mode_i in all states except IDLE.
REQ-024 SHALL keep set counter and way counter, both 0 on entry to CLEAR/LOAD; order is way-inner, set-outer (set0/way0, set0/way1, ..., set SETS-1/way WAYS-1).
REQ-025 SHALL, in CLEAR, drive we_o=1 every cycle with vect_o=CLEAR_VAL, completing in exactly SETS*WAYS cycles.
REQ-026 SHALL, in LOAD, drive s_ready_o=1 and we_o = s_valid_i combinationally, vect_o = s_data_i; a write occurs only on s_valid_i & s_ready_o.
REQ-027 SHALL drive addr_o/way_o from the counters combinationally; counters advance only on a write.
REQ-028 SHALL wrap way counter WAYS-1->0 and increment set counter on that write; set counter wraps at SETS-1 (no out-of-range index ever driven).
REQ-029 SHALL move to DONE in the cycle after the write to set SETS-1/way WAYS-1; DONE lasts one cycle with done_o=1, then IDLE.
REQ-030 SHALL hold s_ready_o=0 and we_o=0 outside LOAD (s_ready_o) and outside CLEAR/LOAD (we_o); vect_o/addr_o/way_o SHALL be 0 when we_o=0.
REQ-031 SHALL, on abort_i=1 in CLEAR or LOAD, suppress we_o and s_ready_o that cycle, go to IDLE next cycle, clear counters, never pulse done_o.
REQ-032 SHALL ignore abort_i in IDLE and DONE.
REQ-033 SHALL give abort_i priority over a simultaneous final write (no write, no done_o).

Reset
REQ-034 SHALL, while rst_i=1 at a clock edge, enter IDLE and zero counters, including mid-sequence; afterwards ready_o=1, busy_o=0, done_o=0, we_o=0, s_ready_o=0, addr_o=0, way_o=0, vect_o=0.
REQ-035 SHALL resume normal operation on the first edge with rst_i=0; start_i on that edge is honoured.

Verification (SETS=4, WAYS=2, DATA_W=8, CLEAR_VAL=8'h00)
REQ-036 Clear: start_i=1, mode_i=0 one cycle -> 8 consecutive we_o cycles, (addr,way) 0/0,0/1,1/0..3/1, vect_o=0; done_o pulse next cycle; ready_o=1 after.
REQ-037 Load with gaps: stream 8'h10..8'h17, s_valid_i low every other cycle -> writes only on valid cycles, data in order matching 0/0..3/1; done_o once.
REQ-038 Abort: abort_i at 4th clear cycle -> that cycle we_o=0, 3 writes total, IDLE next cycle, no done_o; new start writes from 0/0.
REQ-039 Reset mid-load after 5 beats -> all outputs per REQ-034 next cycle; subsequent load writes from 0/0.
REQ-040 start_i pulsed while busy and abort_i coincident with final write -> start ignored; final write suppressed, no done_o.
